// File: rtl/spi_receiver_if.sv
// Word-side handshake bundle of the SPI receiver: parallel word with valid/ready plus
// single-cycle error pulses. The receiver drives it through the master modport.
interface spi_receiver_if #(
    parameter int P_DATA_WIDTH = 8
) ();
    logic                    ready;
    logic                    valid;
    logic [P_DATA_WIDTH-1:0] data;
    logic                    frame_err;
    logic                    overrun;

    modport master (
        input  ready,
        output valid,
        output data,
        output frame_err,
        output overrun
    );

    modport slave (
        output ready,
        input  valid,
        input  data,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/spi_receiver.sv
// SPI mode-0 slave receiver: oversamples asynchronous CS/SCK/MOSI in the clk_100 domain,
// rebuilds each frame into a word and offers it through a one-entry valid/ready buffer.
module spi_receiver #(
    parameter int P_DATA_WIDTH  = 8,
    parameter int P_MSB_FIRST   = 1,
    parameter int P_SYNC_STAGES = 2
) (
    input  logic           clk_100,
    input  logic           s_rst,
    input  logic           cs_i,
    input  logic           sck_i,
    input  logic           mosi_i,
    spi_receiver_if.master rx
);
    localparam int CW = $clog2(P_DATA_WIDTH + 2);
    localparam int FW = $clog2(P_SYNC_STAGES + 2);
    localparam logic [CW-1:0] L_CNT_FULL   = CW'(P_DATA_WIDTH);
    localparam logic [CW-1:0] L_CNT_SAT    = CW'(P_DATA_WIDTH + 1);
    localparam logic [FW-1:0] L_FLUSH_DONE = FW'(P_SYNC_STAGES + 1);

    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_SHIFT     = 2'd2;

    logic [P_SYNC_STAGES-1:0] cs_sync_reg;
    logic [P_SYNC_STAGES-1:0] sck_sync_reg;
    logic [P_SYNC_STAGES-1:0] mosi_sync_reg;
    logic                     cs_d_reg;
    logic                     sck_d_reg;
    logic                     cs_s;
    logic                     sck_s;
    logic                     mosi_s;
    logic                     sck_rise;
    logic                     cs_fall;
    logic                     cs_rise;

    logic [1:0]              state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [P_DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [P_DATA_WIDTH-1:0] shift_in;
    logic [FW-1:0]           flush_cnt_reg, flush_cnt_next;
    logic                    frame_done_reg, frame_done_next;

    logic                    valid_reg;
    logic [P_DATA_WIDTH-1:0] data_reg;
    logic                    frame_err_reg;
    logic                    overrun_reg;

    always_ff @(posedge clk_100) begin
        if (!s_rst) begin
            cs_sync_reg   <= '1;
            sck_sync_reg  <= '0;
            mosi_sync_reg <= '0;
            cs_d_reg      <= 1'b1;
            sck_d_reg     <= 1'b0;
        end else begin
            cs_sync_reg   <= {cs_sync_reg[P_SYNC_STAGES-2:0], cs_i};
            sck_sync_reg  <= {sck_sync_reg[P_SYNC_STAGES-2:0], sck_i};
            mosi_sync_reg <= {mosi_sync_reg[P_SYNC_STAGES-2:0], mosi_i};
            cs_d_reg      <= cs_sync_reg[P_SYNC_STAGES-1];
            sck_d_reg     <= sck_sync_reg[P_SYNC_STAGES-1];
        end
    end

    assign cs_s     = cs_sync_reg[P_SYNC_STAGES-1];
    assign sck_s    = sck_sync_reg[P_SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_reg[P_SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d_reg;
    assign cs_fall  = ~cs_s & cs_d_reg;
    assign cs_rise  = cs_s & ~cs_d_reg;

    generate
        if (P_MSB_FIRST != 0) begin : g_msb_first
            assign shift_in = {shift_reg[P_DATA_WIDTH-2:0], mosi_s};
        end else begin : g_lsb_first
            assign shift_in = {mosi_s, shift_reg[P_DATA_WIDTH-1:1]};
        end
    endgenerate

    // The synchronizer comes out of reset looking idle, so its reset contents are flushed
    // before CS is trusted; otherwise a frame already in flight would be picked up mid-way.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        shift_next      = shift_reg;
        flush_cnt_next  = flush_cnt_reg;
        frame_done_next = 1'b0;
        case (state_reg)
            ST_WAIT_IDLE: begin
                if (flush_cnt_reg != L_FLUSH_DONE) begin
                    flush_cnt_next = flush_cnt_reg + 1'b1;
                end else if (cs_s) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_next = ST_SHIFT;
                    cnt_next   = '0;
                    shift_next = '0;
                end
            end
            ST_SHIFT: begin
                if (sck_rise) begin
                    if (cnt_reg < L_CNT_FULL) begin
                        shift_next = shift_in;
                    end
                    if (cnt_reg != L_CNT_SAT) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                if (cs_rise) begin
                    state_next      = ST_IDLE;
                    frame_done_next = 1'b1;
                end
            end
            default: state_next = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (!s_rst) begin
            state_reg      <= ST_WAIT_IDLE;
            cnt_reg        <= '0;
            shift_reg      <= '0;
            flush_cnt_reg  <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            shift_reg      <= shift_next;
            flush_cnt_reg  <= flush_cnt_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // A completed word may replace the buffered one only when that one leaves this cycle.
    always_ff @(posedge clk_100) begin
        if (!s_rst) begin
            valid_reg     <= 1'b0;
            data_reg      <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            if (valid_reg && rx.ready) begin
                valid_reg <= 1'b0;
            end
            if (frame_done_reg) begin
                if (cnt_reg != L_CNT_FULL) begin
                    frame_err_reg <= 1'b1;
                end else if (!valid_reg || rx.ready) begin
                    data_reg  <= shift_reg;
                    valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end
        end
    end

    assign rx.valid     = valid_reg;
    assign rx.data      = data_reg;
    assign rx.frame_err = frame_err_reg;
    assign rx.overrun   = overrun_reg;
endmodule
